// File: rtl/fp8_mul_pkg.sv
// rtl/fp8_mul_pkg.sv - FP8 (E4M3/E5M2) and bf16 constants, types and decode helpers.
package fp8_mul_pkg;

    localparam int E4M3_BIAS  = 7;
    localparam int E4M3_EXP_W = 4;
    localparam int E4M3_MAN_W = 3;
    localparam int E5M2_BIAS  = 15;
    localparam int E5M2_EXP_W = 5;
    localparam int E5M2_MAN_W = 2;
    localparam int BF16_BIAS  = 127;

    localparam logic [15:0] BF16_QNAN = 16'h7FC0;
    localparam logic [15:0] BF16_PINF = 16'h7F80;

    // Operand value = sig * 2^exp, with exp already scaled by the mantissa width.
    localparam logic signed [6:0] E4M3_SUB_EXP = 7'(1 - E4M3_BIAS - E4M3_MAN_W);
    localparam logic signed [6:0] E4M3_NRM_OFF = 7'(E4M3_BIAS + E4M3_MAN_W);
    localparam logic signed [6:0] E5M2_SUB_EXP = 7'(1 - E5M2_BIAS - E5M2_MAN_W);
    localparam logic signed [6:0] E5M2_NRM_OFF = 7'(E5M2_BIAS + E5M2_MAN_W);

    typedef struct packed {
        logic       sign;
        logic [7:0] exp;
        logic [6:0] frac;
    } bf16_t;

    typedef struct packed {
        logic              zero;
        logic              inf;
        logic              nan;
        logic [3:0]        sig;
        logic signed [6:0] exp;
    } fp8_dec_t;

    function automatic logic [2:0] lead_one(input logic [7:0] v);
        lead_one = '0;
        for (int i = 0; i < 8; i++) begin
            if (v[i]) lead_one = 3'(i);
        end
    endfunction

    function automatic fp8_dec_t fp8_decode(input logic [7:0] v, input logic e5);
        fp8_dec_t d;
        logic [E5M2_EXP_W-1:0] ef5;
        logic [E4M3_EXP_W-1:0] ef4;
        ef5 = v[6 -: E5M2_EXP_W];
        ef4 = v[6 -: E4M3_EXP_W];
        d.zero = (v[6:0] == 7'd0);
        if (e5) begin
            d.nan = (&ef5) && (|v[E5M2_MAN_W-1:0]);
            d.inf = (&ef5) && !(|v[E5M2_MAN_W-1:0]);
            d.sig = {1'b0, |ef5, v[E5M2_MAN_W-1:0]};
            d.exp = (ef5 == '0) ? E5M2_SUB_EXP : $signed({2'b00, ef5}) - E5M2_NRM_OFF;
        end else begin
            d.nan = (&ef4) && (&v[E4M3_MAN_W-1:0]);
            d.inf = 1'b0;
            d.sig = {|ef4, v[E4M3_MAN_W-1:0]};
            d.exp = (ef4 == '0) ? E4M3_SUB_EXP : $signed({3'b000, ef4}) - E4M3_NRM_OFF;
        end
        return d;
    endfunction

endpackage

// File: rtl/fp8_bf16_mul.sv
// rtl/fp8_bf16_mul.sv - combinational exact FP8 x FP8 -> bf16 multiply with special-value handling.
module fp8_bf16_mul
    import fp8_mul_pkg::*;
(
    input  logic        e5m2mode,
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    output logic [15:0] p
);

    fp8_dec_t   da;
    fp8_dec_t   db;
    logic [7:0] sig_p;
    logic [2:0] lead;
    logic [7:0] exp_s;
    logic       sgn;
    bf16_t      res;

    always_comb begin
        da    = fp8_decode(a, e5m2mode);
        db    = fp8_decode(b, e5m2mode);
        sgn   = a[7] ^ b[7];
        sig_p = {4'b0000, da.sig} * {4'b0000, db.sig};
        lead  = lead_one(sig_p);
        // Biased exponent always lands in 95..158, so 8-bit wraparound is exact.
        exp_s = {da.exp[6], da.exp} + {db.exp[6], db.exp} + {5'b00000, lead} + 8'(BF16_BIAS);
        res.sign = sgn;
        res.exp  = exp_s;
        res.frac = 7'(sig_p << (3'd7 - lead));
        if (da.nan || db.nan || (da.inf && db.zero) || (db.inf && da.zero)) begin
            res = BF16_QNAN;
        end else if (da.inf || db.inf) begin
            res = BF16_PINF | {sgn, 15'd0};
        end else if (da.zero || db.zero) begin
            res = {sgn, 15'd0};
        end
    end

    assign p = res;

endmodule

// File: rtl/fp8_outer_mul_pipe.sv
// rtl/fp8_outer_mul_pipe.sv - pipelined FP8 outer-product multiplier with valid/ready handshake.
// Optional tag sideband enabled by FP8_MUL_TAG_EN.
module fp8_outer_mul_pipe
    import fp8_mul_pkg::*;
#(
    parameter int N_ROW       = 2,
    parameter int N_COL       = 3,
    parameter int PIPE_STAGES = 2,
    parameter int TAG_W       = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      e5m2mode,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [N_ROW*8-1:0]        row_vec,
    input  logic [N_COL*8-1:0]        col_vec,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [N_ROW*N_COL*16-1:0] prod
`ifdef FP8_MUL_TAG_EN
    ,
    input  logic [TAG_W-1:0]          tag_in,
    output logic [TAG_W-1:0]          tag_out
`endif
);

    localparam int PW = N_ROW * N_COL * 16;
`ifdef FP8_MUL_TAG_EN
    localparam int DW = PW + TAG_W;
`else
    localparam int DW = PW;
`endif

    if (PIPE_STAGES < 1 || PIPE_STAGES > 4 || TAG_W < 1) begin : g_bad_param
        $error("fp8_outer_mul_pipe: illegal parameter value");
    end

    logic [PW-1:0]          prod_c;
    logic [DW-1:0]          in_word;
    logic [PIPE_STAGES-1:0] vld_q;
    logic [PIPE_STAGES-1:0] vld_d;
    logic [DW-1:0]          dat_q [PIPE_STAGES];
    logic [DW-1:0]          dat_d [PIPE_STAGES];
    logic                   stall;

    for (genvar r = 0; r < N_ROW; r++) begin : g_row
        for (genvar c = 0; c < N_COL; c++) begin : g_col
            fp8_bf16_mul u_mul (
                .e5m2mode (e5m2mode),
                .a        (row_vec[r*8 +: 8]),
                .b        (col_vec[c*8 +: 8]),
                .p        (prod_c[(r*N_COL+c)*16 +: 16])
            );
        end
    end

`ifdef FP8_MUL_TAG_EN
    assign in_word = {tag_in, prod_c};
    assign tag_out = dat_q[PIPE_STAGES-1][PW +: TAG_W];
`else
    assign in_word = prod_c;
`endif

    assign out_valid = vld_q[PIPE_STAGES-1];
    assign prod      = dat_q[PIPE_STAGES-1][PW-1:0];
    assign stall     = out_valid && !out_ready;
    assign in_ready  = !stall && !rst;

    // Global enable: the whole pipe advances together; data only loads behind a valid
    // so the output holds its last product across bubbles.
    always_comb begin
        vld_d = vld_q;
        dat_d = dat_q;
        if (!stall) begin
            vld_d[0] = in_valid;
            if (in_valid) dat_d[0] = in_word;
            for (int s = 1; s < PIPE_STAGES; s++) begin
                vld_d[s] = vld_q[s-1];
                if (vld_q[s-1]) dat_d[s] = dat_q[s-1];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q <= '0;
            for (int s = 0; s < PIPE_STAGES; s++) dat_q[s] <= '0;
        end else begin
            vld_q <= vld_d;
            for (int s = 0; s < PIPE_STAGES; s++) dat_q[s] <= dat_d[s];
        end
    end

endmodule
